// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with a pending-write scoreboard.
//   NUM_RD combinational read ports and one synchronous write port.
//   x0 always reads as zero.
//   A per-register pending bit is set when a producer issues and cleared on write-back.
//   busy_cnt holds a registered count of the pending registers.
//
// Optional build macro REGFILE_BYPASS_EN: forwards WD3 to any read port that
// addresses the register being written in the same cycle, and overrides that
// port's pend bit to match.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   A_rd      packed read addresses, port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   RD        packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pend      per-port flag: the addressed register has an outstanding write
//   A3/WE3/WD3  write address, enable and data; a write also retires the pending bit
//   issue_en/issue_rd  marks issue_rd as pending (newer producer outstanding)
//   a0        registered contents of register A0_INDEX
//   busy_cnt  number of registers currently pending
module regfile_mp_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2,
  parameter int A0_INDEX      = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] A_rd,
  output logic [NUM_RD*DATA_WIDTH-1:0]    RD,
  output logic [NUM_RD-1:0]               pend,
  input  logic [ADDRESS_WIDTH-1:0]        A3,
  input  logic                            WE3,
  input  logic [DATA_WIDTH-1:0]           WD3,
  input  logic                            issue_en,
  input  logic [ADDRESS_WIDTH-1:0]        issue_rd,
  output logic [DATA_WIDTH-1:0]           a0,
  output logic [ADDRESS_WIDTH:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]       pending;
  logic [ADDRESS_WIDTH:0] busy_q;

  logic wr_ok;
  logic iss_ok;
  logic set_new;
  logic clr_old;

  assign wr_ok  = WE3 && (A3 != '0);
  assign iss_ok = issue_en && (issue_rd != '0);

  // A count change happens only on a real transition of a pending bit.
  // When the same register is issued and written together the set wins,
  // so the write must not be counted as a clear.
  assign set_new = iss_ok && !pending[issue_rd];
  assign clr_old = wr_ok && pending[A3] && !(iss_ok && (issue_rd == A3));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[A3] <= WD3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      busy_q  <= '0;
    end else begin
      // Clear first, then set, so a same-register issue overrides the retire.
      if (wr_ok)  pending[A3]       <= 1'b0;
      if (iss_ok) pending[issue_rd] <= 1'b1;
      busy_q <= busy_q + {{ADDRESS_WIDTH{1'b0}}, set_new}
                       - {{ADDRESS_WIDTH{1'b0}}, clr_old};
    end
  end

  assign busy_cnt = busy_q;
  assign a0       = regs[A0_INDEX];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0]    stored;
    assign ra     = A_rd[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign stored = (ra == '0) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_ok && (A3 == ra);
    assign RD[i*DATA_WIDTH +: DATA_WIDTH] = hit ? WD3 : stored;
    assign pend[i] = hit ? (iss_ok && (issue_rd == A3)) : pending[ra];
`else
    assign RD[i*DATA_WIDTH +: DATA_WIDTH] = stored;
    assign pend[i] = pending[ra];
`endif
  end

endmodule
